// File: rtl/adder4_result_stage_if.sv
// Handshake bundle between the 4-bit adder, the result stage and its consumer.
// The master side is the adder/consumer environment; the stage itself uses the slave side.
interface adder4_result_stage_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       sum_in;
  logic             a_msb;
  logic             b_msb;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_sum;
  logic [3:0]       out_flags;
  logic             clr_cnt;
  logic [CNT_W-1:0] carry_cnt;

  modport master (
    output in_valid, sum_in, a_msb, b_msb, out_ready, clr_cnt,
    input  in_ready, out_valid, out_sum, out_flags, carry_cnt
  );

  modport slave (
    input  in_valid, sum_in, a_msb, b_msb, out_ready, clr_cnt,
    output in_ready, out_valid, out_sum, out_flags, carry_cnt
  );
endinterface

// File: rtl/adder4_result_stage.sv
// Two-entry skid buffer behind the 4-bit adder: derives C/Z/N/V per result,
// presents results in FIFO order and keeps a saturating carry-out count.
module adder4_result_stage #(
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  adder4_result_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_head_sum;
  logic [3:0]       r_head_flags;
  logic [3:0]       r_tail_sum;
  logic [3:0]       r_tail_flags;
  logic [CNT_W-1:0] r_carry_cnt;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_load_head_new;
  logic             w_load_head_tail;
  logic             w_load_tail;
  logic [3:0]       w_new_flags;

  // {C,Z,N,V}; Z looks at the nibble only, so a carry-out does not clear it.
  function automatic logic [3:0] calc_flags(
    input logic [4:0] sum,
    input logic       a_msb,
    input logic       b_msb
  );
    logic c;
    logic z;
    logic n;
    logic v;
    c = sum[4];
    z = (sum[3:0] == 4'd0);
    n = sum[3];
    v = (a_msb == b_msb) && (sum[3] != a_msb);
    return {c, z, n, v};
  endfunction

  assign w_new_flags = calc_flags(bus.sum_in, bus.a_msb, bus.b_msb);
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_head_new  = 1'b0;
    w_load_head_tail = 1'b0;
    w_load_tail      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_state_nxt     = ST_ONE;
          w_load_head_new = 1'b1;
        end else begin
          w_state_nxt     = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_push && w_pop) begin
          w_state_nxt     = ST_ONE;
          w_load_head_new = 1'b1;
        end else if (w_push) begin
          w_state_nxt     = ST_FULL;
          w_load_tail     = 1'b1;
        end else if (w_pop) begin
          w_state_nxt     = ST_EMPTY;
        end else begin
          w_state_nxt     = ST_ONE;
        end
      end
      ST_FULL: begin
        if (w_pop) begin
          w_state_nxt      = ST_ONE;
          w_load_head_tail = 1'b1;
        end else begin
          w_state_nxt      = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // in_ready depends on registered state and rst only, never on out_ready.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_in_ready  = ~rst;
        w_out_valid = 1'b0;
      end
      ST_ONE: begin
        w_in_ready  = ~rst;
        w_out_valid = 1'b1;
      end
      ST_FULL: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b1;
      end
      default: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_load_head_new) begin
      r_head_sum   <= bus.sum_in[3:0];
      r_head_flags <= w_new_flags;
    end else if (w_load_head_tail) begin
      r_head_sum   <= r_tail_sum;
      r_head_flags <= r_tail_flags;
    end
    if (w_load_tail) begin
      r_tail_sum   <= bus.sum_in[3:0];
      r_tail_flags <= w_new_flags;
    end
  end

  // Clear wins over a same-cycle carry push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_carry_cnt <= {CNT_W{1'b0}};
    end else if (bus.clr_cnt) begin
      r_carry_cnt <= {CNT_W{1'b0}};
    end else if (w_push && bus.sum_in[4] && (r_carry_cnt != CNT_MAX)) begin
      r_carry_cnt <= r_carry_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_sum   = w_out_valid ? r_head_sum : 4'd0;
  assign bus.out_flags = w_out_valid ? r_head_flags : 4'd0;
  assign bus.carry_cnt = r_carry_cnt;

endmodule

// File: tb/tb_adder4_result_stage.sv
// Scoreboard bench for adder4_result_stage: operands are randomised and the
// expected nibble/flags come from signed/unsigned arithmetic on those operands.
module tb_adder4_result_stage;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    int sum;
    int flags;
  } exp_t;

  logic clk;
  logic rst;
  int   op_a;
  int   op_b;
  int   n_total;
  int   n_bad;
  int   m_cnt;
  exp_t q[$];

  adder4_result_stage_if #(.CNT_W(CNT_W)) bus ();

  adder4_result_stage #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int s;
    int sa;
    int sb;
    int ss;
    int c, z, n, v;
    s  = a + b;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    ss = sa + sb;
    c  = (s > 15) ? 1 : 0;
    z  = ((s % 16) == 0) ? 1 : 0;
    n  = ((s % 16) >= 8) ? 1 : 0;
    v  = (ss > 7 || ss < -8) ? 1 : 0;
    e.sum   = s % 16;
    e.flags = c * 8 + z * 4 + n * 2 + v;
    return e;
  endfunction

  task automatic drive(input int v, input int a, input int b, input int ordy, input int clr);
    logic [4:0] s;
    op_a = a;
    op_b = b;
    s = 5'(a + b);
    bus.in_valid  = (v != 0);
    bus.sum_in    = s;
    bus.a_msb     = s[4] ^ s[4] ^ ((a & 8) != 0);
    bus.b_msb     = ((b & 8) != 0);
    bus.out_ready = (ordy != 0);
    bus.clr_cnt   = (clr != 0);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares presented head against the queue, then applies this edge's push/pop to the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_in_ready", int'(bus.in_ready), 0);
      chk("rst_out_sum", int'(bus.out_sum), 0);
      chk("rst_out_flags", int'(bus.out_flags), 0);
      chk("rst_carry_cnt", int'(bus.carry_cnt), 0);
      q.delete();
      m_cnt = 0;
    end else begin
      bit   e_valid;
      bit   e_rdy;
      bit   m_push;
      exp_t e;
      e_valid = (q.size() != 0);
      e_rdy   = (q.size() < 2);
      chk("out_valid", int'(bus.out_valid), int'(e_valid));
      chk("in_ready", int'(bus.in_ready), int'(e_rdy));
      chk("carry_cnt", int'(bus.carry_cnt), m_cnt);
      if (e_valid) begin
        chk("out_sum", int'(bus.out_sum), q[0].sum);
        chk("out_flags", int'(bus.out_flags), q[0].flags);
      end else begin
        chk("idle_out_sum", int'(bus.out_sum), 0);
        chk("idle_out_flags", int'(bus.out_flags), 0);
      end
      m_push = bus.in_valid && e_rdy;
      if (e_valid && bus.out_ready) void'(q.pop_front());
      if (m_push) begin
        e = model(op_a, op_b);
        q.push_back(e);
      end
      if (bus.clr_cnt) m_cnt = 0;
      else if (m_push && op_a + op_b > 15 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta[4];
    int tbv[4];
    int tf[4];
    int ts[4];
    bit acc;
    int v, ordy, clr;
    n_total = 0;
    n_bad   = 0;
    m_cnt   = 0;
    rst     = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed flag table: 9+8, 7+1, F+1, 8+8
    ta  = '{9, 7, 15, 8};
    tbv = '{8, 1, 1, 8};
    tf  = '{4'b1001, 4'b0011, 4'b1100, 4'b1101};
    ts  = '{1, 8, 0, 0};
    for (int i = 0; i < 4; i++) begin
      drive(1, ta[i], tbv[i], 1, 0);
      cyc(1);
      drive(0, 0, 0, 1, 0);
      @(negedge clk);
      chk("dir_valid", int'(bus.out_valid), 1);
      chk("dir_sum", int'(bus.out_sum), ts[i]);
      chk("dir_flags", int'(bus.out_flags), tf[i]);
      if (i == 0) chk("dir_cnt_first", int'(bus.carry_cnt), 1);
      cyc(1);
    end
    cyc(1);

    // Backpressure: three pushes against a stalled consumer
    drive(1, 0, 1, 0, 0);
    cyc(1);
    drive(1, 1, 1, 0, 0);
    cyc(1);
    drive(1, 1, 2, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", int'(bus.in_ready), 0);
      chk("bp_head_stable", int'(bus.out_sum), 1);
      @(posedge clk);
      #1;
    end
    drive(1, 1, 2, 1, 0);
    cyc(2);
    drive(0, 0, 0, 1, 0);
    cyc(3);

    // Streaming at full throughput
    for (int k = 0; k < 40; k++) begin
      drive(1, $urandom_range(0, 15), $urandom_range(0, 15), 1, 0);
      @(negedge clk);
      chk("stream_in_ready", int'(bus.in_ready), 1);
      if (k > 0) chk("stream_out_valid", int'(bus.out_valid), 1);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 1, 0);
    cyc(2);

    // Carry counter saturation and clear priority
    for (int k = 0; k < 260; k++) begin
      drive(1, 15, $urandom_range(1, 15), 1, 0);
      cyc(1);
    end
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("cnt_saturated", int'(bus.carry_cnt), CNT_MAX);
    @(posedge clk);
    #1;
    drive(1, 15, 1, 1, 1);
    cyc(1);
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("cnt_clr_priority", int'(bus.carry_cnt), 0);
    @(posedge clk);
    #1;
    cyc(2);

    // Random traffic; upstream holds data until accepted
    acc = 1'b1;
    for (int k = 0; k < 400; k++) begin
      ordy = ($urandom_range(0, 3) != 0) ? 1 : 0;
      clr  = ($urandom_range(0, 31) == 0) ? 1 : 0;
      if (!bus.in_valid || acc) begin
        v = int'($urandom_range(0, 1));
        drive(v, $urandom_range(0, 15), $urandom_range(0, 15), ordy, clr);
      end else begin
        drive(1, op_a, op_b, ordy, clr);
      end
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 1, 0);
    cyc(3);

    // Reset while FULL discards everything immediately
    drive(1, 2, 3, 0, 0);
    cyc(1);
    drive(1, 4, 4, 0, 0);
    cyc(1);
    drive(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", int'(bus.out_valid), 0);
    chk("rst_mid_in_ready", int'(bus.in_ready), 0);
    chk("rst_mid_carry_cnt", int'(bus.carry_cnt), 0);
    @(posedge clk);
    #1;
    cyc(1);
    rst = 1'b0;
    drive(1, 3, 3, 0, 0);
    cyc(1);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_valid", int'(bus.out_valid), 1);
    chk("post_rst_sum", int'(bus.out_sum), 6);
    chk("post_rst_alone", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 1, 0);
    cyc(1);
    @(negedge clk);
    chk("post_rst_drained", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/adder4_result_stage.md
# adder4_result_stage

Registered output stage directly downstream of the 4-bit ripple adder (`adder4`). It captures each 5-bit sum, with the two operand MSBs, through a valid/ready handshake. It derives the C/Z/N/V flags and buffers up to two results in a skid buffer so the adder side never sees a combinational path from `out_ready`. It also keeps a saturating count of carry-out results for ALU status readback.

## Interface
- `CNT_W`, default 8: width of the carry-out event counter.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: `sum_in`/`a_msb`/`b_msb` hold a result.
- `in_ready`, output, 1: stage can accept a result this cycle.
- `sum_in`, input, 5: adder SUM; bit 4 is carry-out.
- `a_msb`, input, 1: A[3] of the operands that produced `sum_in`.
- `b_msb`, input, 1: B[3] of the operands that produced `sum_in`.
- `out_valid`, output, 1: head entry is presented.
- `out_ready`, input, 1: consumer takes the head entry this cycle.
- `out_sum`, output, 4: result nibble, `sum_in[3:0]`.
- `out_flags`, output, 4: {C,Z,N,V}, bit 3 = C.
- `clr_cnt`, input, 1: synchronous clear of `carry_cnt`.
- `carry_cnt`, output, CNT_W: number of accepted results with C=1, saturating.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- Flags are computed from the pushed data and stored per entry:
  - C = `sum_in[4]`
  - Z = (`sum_in[3:0]` == 0)
  - N = `sum_in[3]`
  - V = (`a_msb` == `b_msb`) && (`sum_in[3]` != `a_msb`)
- Z refers to the 4-bit result only; a carry-out does not clear Z.
- The buffer is two entries, FIFO order: head (entry 0) and tail (entry 1). `out_sum`/`out_flags` always show the head entry.
- States: EMPTY (0 entries), ONE (1 entry), FULL (2 entries).
  - EMPTY: push -> ONE, data written to head.
  - ONE, push only: -> FULL, data written to tail.
  - ONE, pop only: -> EMPTY.
  - ONE, push and pop in the same cycle: stays ONE; head takes the new data.
  - FULL, pop: -> ONE; tail moves to head. No push is possible in FULL because `in_ready` = 0.
  - FULL: `in_ready` = 0. A valid `sum_in` must be held by upstream and is not lost.
- `in_ready` = (state != FULL) && !`rst`. It is a function of registered state only, with no path from `out_ready`.
- `out_valid` = (state != EMPTY).
- `carry_cnt`:
  - Increments by 1 on each push with C=1.
  - Holds at 2^CNT_W−1 (no wrap).
  - `clr_cnt` has priority: if `clr_cnt` is high, the counter is 0 next cycle even if a push with C=1 occurs in the same cycle.
- Reset mid-operation: all buffered entries are discarded immediately, with no drain.

## Timing
- All outputs are reset values while `rst` is high:
  - state EMPTY
  - `out_valid` = 0
  - `out_sum` = 0
  - `out_flags` = 0
  - `carry_cnt` = 0
  - `in_ready` = 0
- `in_ready` = 1 from the first clock cycle after `rst` deasserts.
- Latency is one cycle. A push at edge k gives `out_valid` = 1 with the data/flags visible after edge k.
- There is no same-cycle pass-through, even when EMPTY and `out_ready` is high.
- Throughput is one result per cycle when `out_ready` is held high: the stage stays in ONE.
- Head outputs are stable while `out_valid && !out_ready`.
- Entry data registers need no reset. Outputs are gated to 0 when EMPTY, so `out_sum`/`out_flags` read 0 when `out_valid` = 0.
- `carry_cnt` updates at the same edge as the push that causes it.

## Test plan
- Reset release, then push `sum_in`=5'h11, `a_msb`=1, `b_msb`=1 (9+8): next cycle `out_valid`=1, `out_sum`=4'h1, `out_flags`=4'b1001, `carry_cnt`=1.
- Push 7+1 (`sum_in`=5'h08, msbs 0/0): flags 4'b0011. Push F+1 (5'h10, msbs 1/0): flags 4'b1100. Push 8+8 (5'h10, msbs 1/1): flags 4'b1101.
- Hold `out_ready`=0 and offer 3 back-to-back pushes (5'h01, 5'h02, 5'h03): `in_ready` drops after the 2nd push, and the 3rd stays pending. Raise `out_ready`: outputs are 1, 2, then 3 in order, with no loss or duplication.
- Continuous `in_valid` and `out_ready`: one result per cycle, 1-cycle latency, `in_ready` never low.
- Push 260 results with C=1 at `CNT_W`=8: `carry_cnt` saturates at 255. Then `clr_cnt` together with a C=1 push: `carry_cnt`=0 next cycle.
- Assert `rst` while FULL: `out_valid`=0, `in_ready`=0, and `carry_cnt`=0 immediately. After release, the first push appears alone.
